multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control sequencer for the 2-bit-opcode CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the datapath strobes one state at a time. Data-memory accesses use a ready handshake with a timeout. The block sits between the instruction register's opcode field and the register file, ALU, PC and data memory. It replaces per-cycle opcode decoding with a state-driven schedule.

## Interface
- TIMEOUT, 15: maximum consecutive MEM cycles with MemReady low before FAULT; range 1..15.
- CNT_W, 16: width of the retired-instruction counter.

- Clk  in  1  clock, rising edge.
- Clear  in  1  reset, synchronous, active-high.
- Run  in  1  level; high allows fetching new instructions.
- op  in  2  opcode from IR: 00 R-type, 01 load, 10 store, 11 branch-if-equal.
- Zero  in  1  ALU zero flag, valid in BRANCH.
- MemReady  in  1  data memory has completed the current access.
- PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp  out  1 each  datapath strobes.
- Busy  out  1  high when the state is neither IDLE nor FAULT.
- Fault  out  1  sticky memory-timeout flag.
- InstrCount  out  CNT_W  count of retired instructions.

## Operation
- Moore machine. Every output is decoded from the registered state and the latched opcode only. Strobes not listed for a state are 0.
- IDLE: no strobes. Run=1 -> FETCH.
- FETCH: IRWrite=1, PCWrite=1 (PC+1). -> DECODE.
- DECODE: latch op into op_q. op_q=00 -> EXEC_R; 01 or 10 -> ADDR; 11 -> BRANCH.
- EXEC_R: ALUSrc=0, ALUOp=1, RegDst=1. -> WB_R.
- WB_R: RegDst=1, RegWrite=1, ALUOp=1. -> retire.
- ADDR: ALUSrc=1, ALUOp=0. Clear the wait counter. -> MEM.
- MEM: ALUSrc=1; MemRead=1 if op_q=01, MemWrite=1 if op_q=10.
  - MemReady=1 -> WB_LD for a load, retire for a store.
  - MemReady=0 -> increment the wait counter. When the counter reaches TIMEOUT -> FAULT; otherwise stay in MEM.
- WB_LD: RegWrite=1, MemtoReg=1, RegDst=0. -> retire.
- BRANCH: Branch=1, ALUSrc=0, ALUOp=0, PCWrite=Zero. -> retire.
- Retire: InstrCount increments by 1 and wraps modulo 2^CNT_W. Next state is FETCH if Run=1, else IDLE.
- FAULT: Fault=1, no strobes. Only Clear leaves this state.

## Timing
- Clear is sampled on the Clk edge and has priority over every other input. It sets state=IDLE, op_q=00, wait counter=0, InstrCount=0, and Fault=0, and all strobes read 0 in the following cycle.
- Cycles per instruction, FETCH to retire inclusive:
  - R-type: 4.
  - Load: 5 + w.
  - Store: 4 + w.
  - Branch: 3.
  - w is the number of MEM cycles with MemReady=0.
- MemReady is sampled only in MEM. When MemReady=1 on the first MEM cycle, MEM lasts exactly one cycle. A MemReady=1 in any other state is ignored.
- Timeout: after TIMEOUT consecutive MemReady=0 cycles the next state is FAULT, and MemRead/MemWrite deassert in that next cycle. If MemReady=1 arrives on the cycle the counter would reach TIMEOUT, MemReady wins.
- Run dropping mid-instruction does not abort it. The instruction completes and retires, then the sequencer goes to IDLE.
- Run=1 at retire gives back-to-back issue: FETCH follows retire with no idle cycle.
- op is sampled only in DECODE. Changes to op in any other state have no effect.
- Strobes are glitch-free, registered-state decode. MemRead/MemWrite stay stable for the whole MEM residency.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants: OP_R=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_BEQ=2'b11.
  - State enum: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM, WB_LD, BRANCH, FAULT.
- One natural sub-module, `mem_wait_timer`: a 4-bit wait counter with clear and increment inputs and an `expired` output, compared against TIMEOUT.
- Next-state logic, output decode and InstrCount live in `multicycle_sequencer`.

## Test plan
- Clear while in MEM with MemRead=1 -> next cycle state=IDLE, all strobes 0, InstrCount=0, Fault=0.
- Run=1, op=00 -> IRWrite+PCWrite at cycle 1, EXEC_R at cycle 3, RegWrite+RegDst at cycle 4. InstrCount=1. FETCH at cycle 5.
- op=01 with MemReady low for 3 cycles -> MemRead high for 4 MEM cycles, then WB_LD with MemtoReg=1 and RegWrite=1. Total 8 cycles.
- op=11 with Zero=1, then op=11 with Zero=0 -> PCWrite=1 in the first BRANCH, PCWrite=0 in the second; Branch=1 in both. InstrCount increments by 2.
- op=10 with MemReady held 0 and TIMEOUT=15 -> MemWrite high for 15 cycles, then Fault=1, Busy=0, and the sequencer stays in FAULT with Run=1 until Clear.
- InstrCount preloaded near wrap (CNT_W=4, 15 retirements), plus Run dropped during EXEC_R -> count wraps to 0, and the instruction in progress completes before IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants and sequencer state encoding for the 2-bit-opcode CPU.
package cpu_pkg;

   localparam logic [1:0] OP_R   = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_BEQ = 2'b11;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      EXEC_R = 4'd3,
      WB_R   = 4'd4,
      ADDR   = 4'd5,
      MEM    = 4'd6,
      WB_LD  = 4'd7,
      BRANCH = 4'd8,
      FAULT  = 4'd9
   } state_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the sequencer and the datapath it steers.
interface multicycle_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             Run;
   logic [1:0]       op;
   logic             Zero;
   logic             MemReady;
   logic             PCWrite;
   logic             IRWrite;
   logic             RegDst;
   logic             RegWrite;
   logic             ALUSrc;
   logic             Branch;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             ALUOp;
   logic             Busy;
   logic             Fault;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      output Run, op, Zero, MemReady,
      input  PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, Branch,
             MemRead, MemWrite, MemtoReg, ALUOp, Busy, Fault, InstrCount
   );

   modport slave (
      input  Run, op, Zero, MemReady,
      output PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, Branch,
             MemRead, MemWrite, MemtoReg, ALUOp, Busy, Fault, InstrCount
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive MEM cycles without MemReady; expired flags that the current
// miss is the one that brings the count to TIMEOUT.
module mem_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic Clk,
   input  logic Clear,
   input  logic i_clr,
   input  logic i_inc,
   output logic expired
);
   localparam logic [4:0] LIMIT = 5'(TIMEOUT);

   logic [3:0] r_cnt;
   logic [4:0] w_cnt_next;

   always_ff @(posedge Clk) begin
      if (Clear || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign w_cnt_next = {1'b0, r_cnt} + 5'd1;
   assign expired    = i_inc && (w_cnt_next >= LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: Moore FSM stepping fetch/decode/execute/mem/wb,
// with a timed data-memory handshake and a retired-instruction counter.
//
// state  | meaning
// IDLE   | waiting for Run
// FETCH  | load IR, PC <= PC+1
// DECODE | latch opcode, pick the execution path
// EXEC_R | R-type ALU operation
// WB_R   | R-type register write, retire
// ADDR   | load/store address computation, reset wait timer
// MEM    | data-memory access, waits on MemReady
// WB_LD  | load register write, retire
// BRANCH | compare and conditional PC write, retire
// FAULT  | memory timeout, held until Clear
module multicycle_sequencer
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic                    Clk,
   input  logic                    Clear,
   multicycle_sequencer_if.slave   bus
);
   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_op_q;
   logic [CNT_W-1:0] r_instr_count;
   logic             w_retire;
   logic             w_tmr_clr;
   logic             w_tmr_inc;
   logic             w_expired;

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .Clk     (Clk),
      .Clear   (Clear),
      .i_clr   (w_tmr_clr),
      .i_inc   (w_tmr_inc),
      .expired (w_expired)
   );

   always_ff @(posedge Clk) begin
      if (Clear) begin
         r_state       <= IDLE;
         r_op_q        <= OP_R;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == DECODE) r_op_q <= bus.op;
         if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      w_tmr_clr = 1'b0;
      w_tmr_inc = 1'b0;
      case (r_state)
         IDLE:   if (bus.Run) w_next = FETCH;
         FETCH:  w_next = DECODE;
         DECODE: begin
            case (bus.op)
               OP_R:         w_next = EXEC_R;
               OP_LW, OP_SW: w_next = ADDR;
               default:      w_next = BRANCH;
            endcase
         end
         EXEC_R: w_next = WB_R;
         WB_R:   w_retire = 1'b1;
         ADDR: begin
            w_tmr_clr = 1'b1;
            w_next    = MEM;
         end
         MEM: begin
            // A late MemReady on the would-be timeout cycle still completes the access.
            if (bus.MemReady) begin
               if (r_op_q == OP_LW) w_next = WB_LD;
               else                 w_retire = 1'b1;
            end else begin
               w_tmr_inc = 1'b1;
               if (w_expired) w_next = FAULT;
            end
         end
         WB_LD:  w_retire = 1'b1;
         BRANCH: w_retire = 1'b1;
         FAULT:  w_next = FAULT;
         default: w_next = IDLE;
      endcase
      if (w_retire) w_next = bus.Run ? FETCH : IDLE;
   end

   always_comb begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegDst   = 1'b0;
      bus.RegWrite = 1'b0;
      bus.ALUSrc   = 1'b0;
      bus.Branch   = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.ALUOp    = 1'b0;
      case (r_state)
         FETCH: begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
         end
         EXEC_R: begin
            bus.ALUOp  = 1'b1;
            bus.RegDst = 1'b1;
         end
         WB_R: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
            bus.ALUOp    = 1'b1;
         end
         ADDR: bus.ALUSrc = 1'b1;
         MEM: begin
            bus.ALUSrc   = 1'b1;
            bus.MemRead  = (r_op_q == OP_LW);
            bus.MemWrite = (r_op_q == OP_SW);
         end
         WB_LD: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         BRANCH: begin
            bus.Branch  = 1'b1;
            bus.PCWrite = bus.Zero;
         end
         default: ;
      endcase
   end

   assign bus.Busy       = (r_state != IDLE) && (r_state != FAULT);
   assign bus.Fault      = (r_state == FAULT);
   assign bus.InstrCount = r_instr_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus queues per-cycle expected
// strobe/count vectors, a negedge monitor pops and compares them.
module tb_multicycle_sequencer;
   import cpu_pkg::*;

   // {PCWrite,IRWrite,RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg,ALUOp,Busy,Fault}
   localparam logic [11:0] E_IDLE   = 12'b0000_0000_0000;
   localparam logic [11:0] E_FETCH  = 12'b1100_0000_0010;
   localparam logic [11:0] E_DECODE = 12'b0000_0000_0010;
   localparam logic [11:0] E_EXEC_R = 12'b0010_0000_0110;
   localparam logic [11:0] E_WB_R   = 12'b0011_0000_0110;
   localparam logic [11:0] E_ADDR   = 12'b0000_1000_0010;
   localparam logic [11:0] E_MEM_LD = 12'b0000_1010_0010;
   localparam logic [11:0] E_MEM_SW = 12'b0000_1001_0010;
   localparam logic [11:0] E_WB_LD  = 12'b0001_0000_1010;
   localparam logic [11:0] E_BR_Z   = 12'b1000_0100_0010;
   localparam logic [11:0] E_BR_NZ  = 12'b0000_0100_0010;
   localparam logic [11:0] E_FAULT  = 12'b0000_0000_0001;

   typedef struct {
      logic [11:0] e;
      logic [3:0]  c;
      string       nm;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Clear;
   exp_t        sb[$];
   exp_t        mx;
   logic [11:0] act;
   logic [3:0]  exp_cnt = 4'd0;
   int          checks = 0;
   int          failures = 0;

   always #5 Clk = ~Clk;

   multicycle_sequencer_if #(.CNT_W(4)) bus ();

   multicycle_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
      .Clk   (Clk),
      .Clear (Clear),
      .bus   (bus)
   );

   always @(negedge Clk) begin
      if (sb.size() != 0) begin
         mx  = sb.pop_front();
         act = {bus.PCWrite, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.Branch,
                bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.ALUOp, bus.Busy, bus.Fault};
         checks++;
         if (act !== mx.e || bus.InstrCount !== mx.c) begin
            failures++;
            $display("FAIL %s: got strobes=%b count=%0d, expected strobes=%b count=%0d",
                     mx.nm, act, bus.InstrCount, mx.e, mx.c);
         end
      end
   end

   task automatic chk(input logic cond, input string nm);
      checks++;
      if (cond !== 1'b1) begin
         failures++;
         $display("FAIL %s: strobes=%b busy=%b fault=%b count=%0d", nm,
                  {bus.PCWrite, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.Branch,
                   bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.ALUOp},
                  bus.Busy, bus.Fault, bus.InstrCount);
      end
   endtask

   // Drive inputs for one cycle; queue what the outputs must be after the edge.
   task automatic cyc(input logic clr, input logic run, input logic [1:0] opv,
                      input logic z, input logic mr, input logic ret,
                      input logic [11:0] e, input string nm);
      exp_t t;
      Clear        = clr;
      bus.Run      = run;
      bus.op       = opv;
      bus.Zero     = z;
      bus.MemReady = mr;
      @(posedge Clk);
      if (clr)      exp_cnt = 4'd0;
      else if (ret) exp_cnt = exp_cnt + 4'd1;
      t.e  = e;
      t.c  = exp_cnt;
      t.nm = nm;
      sb.push_back(t);
      #1;
   endtask

   // Each instruction task starts with the sequencer already in FETCH.
   task automatic instr_r(input logic rn);
      cyc(0, 1,  OP_BEQ, 1, 1, 0, E_DECODE, "r_decode");
      cyc(0, 1,  OP_R,   1, 1, 0, E_EXEC_R, "r_exec");
      cyc(0, rn, OP_BEQ, 1, 1, 0, E_WB_R,   "r_wb");
      cyc(0, rn, OP_BEQ, 1, 1, 1, rn ? E_FETCH : E_IDLE, "r_retire");
   endtask

   task automatic instr_ld(input int w, input logic rn);
      cyc(0, 1, OP_SW, 1, 1, 0, E_DECODE, "ld_decode");
      cyc(0, 1, OP_LW, 1, 1, 0, E_ADDR,   "ld_addr");
      cyc(0, 1, OP_SW, 1, 1, 0, E_MEM_LD, "ld_mem");
      for (int i = 0; i < w; i++) cyc(0, 1, OP_SW, 1, 0, 0, E_MEM_LD, "ld_wait");
      cyc(0, 1,  OP_SW, 1, 1, 0, E_WB_LD, "ld_wb");
      cyc(0, rn, OP_SW, 1, 1, 1, rn ? E_FETCH : E_IDLE, "ld_retire");
   endtask

   task automatic instr_sw(input int w, input logic rn);
      cyc(0, 1, OP_LW, 1, 1, 0, E_DECODE, "sw_decode");
      cyc(0, 1, OP_SW, 1, 1, 0, E_ADDR,   "sw_addr");
      cyc(0, 1, OP_LW, 1, 1, 0, E_MEM_SW, "sw_mem");
      for (int i = 0; i < w; i++) cyc(0, 1, OP_LW, 1, 0, 0, E_MEM_SW, "sw_wait");
      cyc(0, rn, OP_LW, 1, 1, 1, rn ? E_FETCH : E_IDLE, "sw_retire");
   endtask

   task automatic instr_br(input logic z, input logic rn);
      cyc(0, 1,  OP_R,   ~z, 1, 0, E_DECODE, "br_decode");
      cyc(0, 1,  OP_BEQ, z,  1, 0, z ? E_BR_Z : E_BR_NZ, "br_branch");
      cyc(0, rn, OP_R,   z,  1, 1, rn ? E_FETCH : E_IDLE, "br_retire");
   endtask

   initial begin
      cyc(1, 0, OP_R, 0, 0, 0, E_IDLE, "reset");
      chk(bus.PCWrite === 1'b0 && bus.IRWrite === 1'b0 && bus.RegDst === 1'b0 &&
          bus.RegWrite === 1'b0 && bus.ALUSrc === 1'b0 && bus.Branch === 1'b0 &&
          bus.MemRead === 1'b0 && bus.MemWrite === 1'b0 && bus.MemtoReg === 1'b0 &&
          bus.ALUOp === 1'b0 && bus.Busy === 1'b0 && bus.Fault === 1'b0 &&
          bus.InstrCount === 4'd0, "reset_state");
      cyc(1, 0, OP_R, 0, 0, 0, E_IDLE, "reset_hold");
      cyc(0, 0, OP_R, 1, 1, 0, E_IDLE, "idle_no_run");
      cyc(0, 1, OP_R, 1, 1, 0, E_FETCH, "first_fetch");

      instr_r(1);
      instr_ld(3, 1);
      instr_br(1, 1);
      instr_br(0, 1);
      instr_sw(14, 1);
      instr_ld(0, 1);
      for (int k = 0; k < 9; k++) instr_r(1);
      instr_r(0);
      cyc(0, 0, OP_R, 1, 1, 0, E_IDLE, "idle_after_wrap");

      cyc(0, 1, OP_R,  1, 1, 0, E_FETCH,  "to_fetch");
      cyc(0, 1, OP_LW, 1, 1, 0, E_DECODE, "to_decode");
      cyc(0, 1, OP_SW, 1, 1, 0, E_ADDR,   "to_addr");
      cyc(0, 1, OP_LW, 1, 0, 0, E_MEM_SW, "to_mem");
      for (int i = 0; i < 14; i++) cyc(0, 1, OP_LW, 1, 0, 0, E_MEM_SW, "to_wait");
      cyc(0, 1, OP_LW, 1, 0, 0, E_FAULT, "timeout");
      chk(bus.Fault === 1'b1 && bus.Busy === 1'b0 && bus.MemWrite === 1'b0 &&
          bus.MemRead === 1'b0, "expired_wait");
      for (int i = 0; i < 3; i++) cyc(0, 1, OP_R, 1, 1, 0, E_FAULT, "fault_hold");
      chk(bus.Fault === 1'b1 && bus.Busy === 1'b0 && bus.IRWrite === 1'b0, "fault_sticky");
      cyc(1, 1, OP_R, 1, 1, 0, E_IDLE, "fault_clear");

      cyc(0, 1, OP_R, 1, 1, 0, E_FETCH, "refetch");
      instr_r(1);
      cyc(0, 1, OP_SW, 1, 1, 0, E_DECODE, "cl_decode");
      cyc(0, 1, OP_LW, 1, 1, 0, E_ADDR,   "cl_addr");
      cyc(0, 1, OP_SW, 1, 0, 0, E_MEM_LD, "cl_mem");
      cyc(1, 1, OP_SW, 1, 0, 0, E_IDLE,   "clear_in_mem");
      chk(bus.MemRead === 1'b0 && bus.Busy === 1'b0 && bus.Fault === 1'b0 &&
          bus.InstrCount === 4'd0, "clear_in_mem_state");
      cyc(0, 0, OP_R,  1, 1, 0, E_IDLE,   "idle_after_clear");

      @(negedge Clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
